// File: rtl/mdu_ctrl_pkg.sv
// Shared opcodes and FSM encodings for the multiply/divide sequencer.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
module mdu_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  div_mode,
    input  logic [DATA_WIDTH-1:0] ph,
    input  logic [DATA_WIDTH-1:0] pl,
    input  logic [DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0] ph_next,
    output logic [DATA_WIDTH-1:0] pl_next
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  ge;

    always_comb begin
        sum     = {1'b0, ph} + (pl[0] ? {1'b0, opnd} : '0);
        shifted = {ph, pl[DATA_WIDTH-1]};
        // Compare before subtracting so a zero divisor always yields quotient bit 1.
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[DATA_WIDTH-1:0] - opnd;
        if (div_mode) begin
            ph_next = ge ? diff : shifted[DATA_WIDTH-1:0];
            pl_next = {pl[DATA_WIDTH-2:0], ge};
        end else begin
            ph_next = sum[DATA_WIDTH:1];
            pl_next = {sum[0], pl[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer: FSM, iteration counter, sign fix and HI/LO ownership.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            op_ex,
    input  logic                  op_valid,
    input  logic                  rd_hilo,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] a_ex,
    input  logic [DATA_WIDTH-1:0] b_ex,
    output logic                  busy,
    output logic                  stall_ex,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CW = $clog2(DATA_WIDTH);

    mdu_state_e            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] ph, pl, opnd;
    logic [DATA_WIDTH-1:0] ph_next, pl_next;
    logic                  is_div, neg_q, neg_r;

    logic                  op_signed, a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_abs, b_abs;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] fix_hi, fix_lo;

    always_comb begin
        op_signed = (op_ex == MDU_MULT) || (op_ex == MDU_DIV);
        a_neg     = op_signed & a_ex[DATA_WIDTH-1];
        b_neg     = op_signed & b_ex[DATA_WIDTH-1];
        a_abs     = a_neg ? -a_ex : a_ex;
        b_abs     = b_neg ? -b_ex : b_ex;
        prod      = neg_q ? -{ph, pl} : {ph, pl};
        if (is_div) begin
            fix_hi = neg_r ? -ph : ph;
            fix_lo = neg_q ? -pl : pl;
        end else begin
            fix_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            fix_lo = prod[DATA_WIDTH-1:0];
        end
    end

    assign stall_ex = (busy & op_valid & (op_ex != MDU_NOP)) | (busy & rd_hilo);

    mdu_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .div_mode (state == S_DIV),
        .ph       (ph),
        .pl       (pl),
        .opnd     (opnd),
        .ph_next  (ph_next),
        .pl_next  (pl_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            ph     <= '0;
            pl     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (op_valid) begin
                    case (op_ex)
                        MDU_MULT, MDU_MULTU: begin
                            state  <= S_MUL;
                            busy   <= 1'b1;
                            cnt    <= CW'(DATA_WIDTH - 1);
                            ph     <= '0;
                            pl     <= b_abs;
                            opnd   <= a_abs;
                            is_div <= 1'b0;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= 1'b0;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state  <= S_DIV;
                            busy   <= 1'b1;
                            cnt    <= CW'(DATA_WIDTH - 1);
                            ph     <= '0;
                            pl     <= a_abs;
                            opnd   <= b_abs;
                            is_div <= 1'b1;
                            // Divide by zero leaves the all-ones quotient unsigned.
                            neg_q  <= (a_neg ^ b_neg) & (b_ex != '0);
                            neg_r  <= a_neg;
                        end
                        MDU_MTHI: hi <= a_ex;
                        MDU_MTLO: lo <= a_ex;
                        default: ;
                    endcase
                end
                S_MUL, S_DIV: begin
                    ph <= ph_next;
                    pl <= pl_next;
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
